// File: rtl/logic_unit_seq.sv
// Sequencer wrapping an external combinational logic unit: latches a request, samples the
// unit's result one cycle later and holds it behind a valid/ready handshake.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lu_f1,
  output logic             lu_f0,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_zero,
  output logic             res_illegal,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q;
  logic             lu_f1_q;
  logic             lu_f0_q;
  logic [WIDTH-1:0] lu_a_q;
  logic [WIDTH-1:0] lu_b_q;
  logic [WIDTH-1:0] result_q;
  logic             res_zero_q;
  logic             res_illegal_q;
  logic [15:0]      op_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      lu_f1_q       <= 1'b0;
      lu_f0_q       <= 1'b0;
      lu_a_q        <= '0;
      lu_b_q        <= '0;
      result_q      <= '0;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            lu_f1_q <= op[1];
            lu_f0_q <= op[0];
            lu_a_q  <= a;
            lu_b_q  <= b;
            state_q <= StExec;
          end
        end
        StExec: begin
          // The illegal flag follows the latched opcode, not the live op input.
          result_q      <= lu_out;
          res_zero_q    <= (lu_out == '0);
          res_illegal_q <= ~(lu_f1_q | lu_f0_q);
          state_q       <= StDone;
        end
        StDone: begin
          if (res_ready) begin
            op_count_q <= op_count_q + 16'd1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign res_valid   = (state_q == StDone);
  assign lu_f1       = lu_f1_q;
  assign lu_f0       = lu_f0_q;
  assign lu_a        = lu_a_q;
  assign lu_b        = lu_b_q;
  assign result      = result_q;
  assign res_zero    = res_zero_q;
  assign res_illegal = res_illegal_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Randomized scoreboard bench for logic_unit_seq with a behavioural logic-unit model.
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        lu_f1;
  logic        lu_f0;
  logic [31:0] lu_a;
  logic [31:0] lu_b;
  logic [31:0] lu_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] result;
  logic        res_zero;
  logic        res_illegal;
  logic [15:0] op_count;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_cnt = '0;

  logic_unit_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .lu_f1      (lu_f1),
    .lu_f0      (lu_f0),
    .lu_a       (lu_a),
    .lu_b       (lu_b),
    .lu_out     (lu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .res_zero   (res_zero),
    .res_illegal(res_illegal),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    case (o)
      2'b01:   return x & y;
      2'b10:   return x | y;
      2'b11:   return x ^ y;
      default: return 32'h0;
    endcase
  endfunction

  // Downstream logic unit as seen by the DUT.
  always_comb lu_out = ref_op({lu_f1, lu_f0}, lu_a, lu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares the presented result whenever the consumer takes it.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected actual=result %h required=no result", result);
      end else begin
        me = sbq.pop_front();
        chk("mon_result", result, me.res);
        chk("mon_zero", 32'(res_zero), 32'(me.zero));
        chk("mon_illegal", 32'(res_illegal), 32'(me.ill));
        chk("mon_count", 32'(op_count), 32'(me.cnt));
      end
    end
  end

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic txn(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                     input int hold, input logic [31:0] exp_res);
    int   waitc = 0;
    exp_t e;
    while (in_ready !== 1'b1 && waitc < 10) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    op = t_op; a = t_a; b = t_b; in_valid = 1'b1; res_ready = (hold == 0);
    e.res = exp_res; e.zero = (exp_res == 32'h0); e.ill = (t_op == 2'b00); e.cnt = model_cnt;
    sbq.push_back(e);
    @(posedge clk); #1;
    // Junk request while busy must be ignored.
    op = 2'($urandom); a = $urandom; b = $urandom;
    chk("exec_lu_f1", 32'(lu_f1), 32'(t_op[1]));
    chk("exec_lu_f0", 32'(lu_f0), 32'(t_op[0]));
    chk("exec_lu_a", lu_a, t_a);
    chk("exec_lu_b", lu_b, t_b);
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    chk("exec_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    chk("done_res_valid", 32'(res_valid), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_result", result, exp_res);
      chk("hold_zero", 32'(res_zero), 32'(exp_res == 32'h0));
      chk("hold_illegal", 32'(res_illegal), 32'(t_op == 2'b00));
      chk("hold_lu_a", lu_a, t_a);
      chk("hold_lu_b", lu_b, t_b);
      chk("hold_lu_op", 32'({lu_f1, lu_f0}), 32'(t_op));
      chk("hold_count", 32'(op_count), 32'(model_cnt));
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    model_cnt = model_cnt + 16'd1;
    res_ready = 1'b0;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_res_valid", 32'(res_valid), 32'd0);
    chk("post_count", 32'(op_count), 32'(model_cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_lu_op"}, 32'({lu_f1, lu_f0}), 32'd0);
    chk({tag, "_lu_a"}, lu_a, 32'h0);
    chk({tag, "_lu_b"}, lu_b, 32'h0);
    chk({tag, "_result"}, result, 32'h0);
    chk({tag, "_flags"}, 32'({res_zero, res_illegal}), 32'd0);
    chk({tag, "_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    #3;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    txn(2'b01, 32'hDC754CD2, 32'h4124F055, 0, 32'h40244050);
    txn(2'b10, 32'hDC754CD2, 32'h4124F055, 0, 32'hDD75FCD7);
    txn(2'b11, 32'hDC754CD2, 32'h4124F055, 0, 32'h9D51BC87);
    r_a = $urandom; r_b = $urandom;
    txn(2'b01, r_a, r_b, 5, ref_op(2'b01, r_a, r_b));
    txn(2'b00, $urandom, $urandom, 1, 32'h0);
    txn(2'b01, 32'hFFFF0000, 32'h0000FFFF, 0, 32'h0);

    for (int n = 0; n < 200; n++) begin
      r_op = 2'($urandom); r_a = $urandom; r_b = $urandom;
      if ($urandom_range(0, 3) == 0) r_b = ~r_a;
      txn(r_op, r_a, r_b, int'($urandom_range(0, 3)), ref_op(r_op, r_a, r_b));
    end

    // Reset while in EXEC abandons the transaction.
    op = 2'b11; a = $urandom; b = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midrst_in_exec", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    model_cnt = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 32'(res_valid), 32'd0);
      chk("midrst_count", 32'(op_count), 32'd0);
    end
    res_ready = 1'b0;

    // Preload the counter near its top to exercise the wrap cheaply.
    force dut.op_count_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.op_count_q;
    model_cnt = 16'hFFFE;
    chk("wrap_preload", 32'(op_count), 32'h0000FFFE);
    for (int n = 0; n < 3; n++) begin
      r_op = 2'($urandom); r_a = $urandom; r_b = $urandom;
      txn(r_op, r_a, r_b, 0, ref_op(r_op, r_a, r_b));
      if (n == 1) chk("wrap_zero", 32'(op_count), 32'h0);
    end

    chk("sb_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
